// File: rtl/reg_prio_n_be.sv
// N-write-port register with fixed per-lane priority (port 0 wins), byte-lane
// enables, one-level rollback, write-event reporting and a saturating conflict counter.
module reg_prio_n_be #(
  parameter int                 width  = 32,
  parameter int                 nports = 2,
  parameter int                 lanew  = 8,
  parameter logic [width-1:0]   init   = '0,
  parameter int                 cntw   = 8,
  parameter int                 pw     = (nports > 1) ? $clog2(nports) : 1,
  localparam int                lanes  = width / lanew
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [nports*width-1:0]   D_IN,
  input  logic [nports-1:0]         EN,
  input  logic [nports*lanes-1:0]   BE,
  input  logic                      RESTORE,
  input  logic                      CLR_CNT,
  output logic [width-1:0]          Q_OUT,
  output logic [width-1:0]          Q_PREV,
  output logic                      WR_VALID,
  output logic [pw-1:0]             WR_PORT,
  output logic [cntw-1:0]           CONFLICTS
);

  logic [width-1:0] q_out_q, q_out_d;
  logic [width-1:0] q_prev_q, q_prev_d;
  logic             wr_valid_q, wr_valid_d;
  logic [pw-1:0]    wr_port_q, wr_port_d;
  logic [cntw-1:0]  conflicts_q, conflicts_d;

  logic [width-1:0]  merged;
  logic [lanes-1:0]  lane_written;
  logic [nports-1:0] active;
  logic [pw-1:0]     first_port;
  logic              multi_active;
  logic              commit;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    merged       = q_out_q;
    lane_written = '0;
    active       = '0;
    first_port   = '0;
    // Scan ports from lowest priority upward so the lowest index overwrites last.
    for (int i = nports - 1; i >= 0; i--) begin
      active[i] = EN[i] && (|BE[i*lanes +: lanes]);
      if (active[i]) first_port = pw'(i);
      for (int l = 0; l < lanes; l++) begin
        if (EN[i] && BE[i*lanes + l]) begin
          merged[l*lanew +: lanew] = D_IN[i*width + l*lanew +: lanew];
          lane_written[l]          = 1'b1;
        end
      end
    end
    // Two or more bits set iff clearing the lowest set bit leaves something.
    multi_active = |(active & (active - 1'b1));
    commit       = (|lane_written) && !RESTORE;
  end

  always_comb begin
    q_out_d     = q_out_q;
    q_prev_d    = q_prev_q;
    wr_valid_d  = 1'b0;
    wr_port_d   = wr_port_q;
    conflicts_d = conflicts_q;

    if (RESTORE) begin
      q_out_d = q_prev_q;
    end else if (commit) begin
      q_out_d    = merged;
      q_prev_d   = q_out_q;
      wr_valid_d = 1'b1;
      wr_port_d  = first_port;
    end

    // Conflicts are counted even when RESTORE discards the writes.
    if (CLR_CNT) begin
      conflicts_d = '0;
    end else if (multi_active && (conflicts_q != {cntw{1'b1}})) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_out_q     <= init;
      q_prev_q    <= init;
      wr_valid_q  <= 1'b0;
      wr_port_q   <= '0;
      conflicts_q <= '0;
    end else begin
      q_out_q     <= q_out_d;
      q_prev_q    <= q_prev_d;
      wr_valid_q  <= wr_valid_d;
      wr_port_q   <= wr_port_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign Q_OUT     = q_out_q;
  assign Q_PREV    = q_prev_q;
  assign WR_VALID  = wr_valid_q;
  assign WR_PORT   = wr_port_q;
  assign CONFLICTS = conflicts_q;

endmodule

// File: tb/tb_reg_prio_n_be.sv
// Self-checking bench for reg_prio_n_be: directed scenarios followed by random
// traffic, all checked against a lane-by-lane behavioural model.
module tb_reg_prio_n_be;

  localparam int W = 32;
  localparam int NP = 3;
  localparam int LN = 4;

  logic           CLK;
  logic           RST;
  logic [NP*W-1:0]  d_in;
  logic [NP-1:0]    en;
  logic [NP*LN-1:0] be;
  logic           restore, clr_cnt;

  logic [W-1:0] q_out, q_prev, q_out_c, q_prev_c;
  logic         wr_valid, wr_valid_c;
  logic [1:0]   wr_port, wr_port_c;
  logic [7:0]   conflicts;
  logic [1:0]   conflicts_c;

  reg_prio_n_be #(.width(W), .nports(NP), .lanew(8), .init('0), .cntw(8)) dut (
    .CLK(CLK), .RST(RST), .D_IN(d_in), .EN(en), .BE(be), .RESTORE(restore),
    .CLR_CNT(clr_cnt), .Q_OUT(q_out), .Q_PREV(q_prev), .WR_VALID(wr_valid),
    .WR_PORT(wr_port), .CONFLICTS(conflicts)
  );

  // Narrow-counter instance sharing the same stimulus to exercise saturation.
  reg_prio_n_be #(.width(W), .nports(NP), .lanew(8), .init('0), .cntw(2)) dut_c (
    .CLK(CLK), .RST(RST), .D_IN(d_in), .EN(en), .BE(be), .RESTORE(restore),
    .CLR_CNT(clr_cnt), .Q_OUT(q_out_c), .Q_PREV(q_prev_c), .WR_VALID(wr_valid_c),
    .WR_PORT(wr_port_c), .CONFLICTS(conflicts_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_q, m_prev;
  logic         m_valid;
  int           m_port;
  int           m_cnt8, m_cnt2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_prev = '0; m_valid = 1'b0; m_port = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // Applies the documented rules to the inputs currently being driven.
  task automatic model_step();
    int n_active;
    int lowest;
    bit written;
    logic [W-1:0] nxt;
    n_active = 0;
    lowest   = -1;
    for (int i = 0; i < NP; i++) begin
      if (en[i] && be[i*LN +: LN] != 0) begin
        n_active++;
        if (lowest < 0) lowest = i;
      end
    end
    if (clr_cnt) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (n_active >= 2) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    nxt = m_q;
    written = 1'b0;
    for (int l = 0; l < LN; l++) begin
      for (int i = 0; i < NP; i++) begin
        if (en[i] && be[i*LN + l]) begin
          nxt[l*8 +: 8] = d_in[i*W + l*8 +: 8];
          written = 1'b1;
          break;
        end
      end
    end
    if (restore) begin
      m_q = m_prev;
      m_valid = 1'b0;
    end else if (written) begin
      m_prev  = m_q;
      m_q     = nxt;
      m_valid = 1'b1;
      m_port  = lowest;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},      64'(q_out),       64'(m_q));
    check({tag, ".prev"},   64'(q_prev),      64'(m_prev));
    check({tag, ".valid"},  64'(wr_valid),    64'(m_valid));
    check({tag, ".port"},   64'(wr_port),     64'(m_port));
    check({tag, ".cnt8"},   64'(conflicts),   64'(m_cnt8));
    check({tag, ".cnt2"},   64'(conflicts_c), 64'(m_cnt2));
    check({tag, ".q_c"},    64'(q_out_c),     64'(m_q));
  endtask

  task automatic step(input string tag, input logic [NP-1:0] e, input logic [NP*LN-1:0] b,
                      input logic [NP*W-1:0] d, input logic rs, input logic cc);
    @(negedge CLK);
    en = e; be = b; d_in = d; restore = rs; clr_cnt = cc;
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    en = '0; be = '0; d_in = '0; restore = 1'b0; clr_cnt = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    en = '0; be = '0; d_in = '0; restore = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    RST = 1'b0;

    for (int k = 0; k < 10; k++) idle("idle");

    // Single port 1 write
    step("single", 3'b010, {4'h0, 4'hF, 4'h0}, {32'h0, 32'hAABBCCDD, 32'h0}, 1'b0, 1'b0);
    check("single.q_exp", 64'(q_out), 64'hAABBCCDD);
    check("single.port_exp", 64'(wr_port), 64'd1);

    // Per-lane priority from a cleared register
    pulse_reset();
    step("prio", 3'b111, {4'b1111, 4'b0011, 4'b0001},
         {32'h33333333, 32'h22222222, 32'h11111111}, 1'b0, 1'b0);
    check("prio.q_exp", 64'(q_out), 64'h33332211);
    check("prio.port_exp", 64'(wr_port), 64'd0);
    check("prio.cnt_exp", 64'(conflicts), 64'd1);

    // Rollback
    step("rb.w1", 3'b001, 12'h00F, {64'h0, 32'h1}, 1'b0, 1'b0);
    step("rb.w2", 3'b001, 12'h00F, {64'h0, 32'h2}, 1'b0, 1'b0);
    check("rb.prev_exp", 64'(q_prev), 64'h1);
    step("rb.restore", 3'b001, 12'h00F, {64'h0, 32'h5}, 1'b1, 1'b0);
    check("rb.q_exp", 64'(q_out), 64'h1);
    check("rb.valid_exp", 64'(wr_valid), 64'h0);
    step("rb.restore2", 3'b000, 12'h000, '0, 1'b1, 1'b0);
    check("rb.q2_exp", 64'(q_out), 64'h1);
    step("rb.after", 3'b100, 12'hF00, {32'hCAFE0001, 64'h0}, 1'b0, 1'b0);

    // Counter saturation and clear-over-increment
    step("cnt.clr", 3'b000, 12'h000, '0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)
      step("cnt.sat", 3'b011, 12'h0FF, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    check("cnt.sat_exp", 64'(conflicts_c), 64'd3);
    step("cnt.clr_conf", 3'b011, 12'h0FF, {$urandom, $urandom, $urandom}, 1'b0, 1'b1);
    check("cnt.clr_exp", 64'(conflicts_c), 64'd0);

    // Active port with no lane enables is inactive
    step("be0", 3'b011, 12'h0F0, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);

    // Async reset between edges while a write is pending
    @(negedge CLK);
    en = 3'b001; be = 12'h00F; d_in = {64'h0, 32'hDEADBEEF}; restore = 1'b0; clr_cnt = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("arst.mid");
    @(posedge CLK);
    #1;
    check_all("arst.held");
    @(negedge CLK);
    en = '0; be = '0; d_in = '0;
    RST = 1'b0;
    idle("arst.after");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [NP-1:0]    e;
      logic [NP*LN-1:0] b;
      e = NP'($urandom_range(0, 7));
      b = (NP*LN)'($urandom);
      if ($urandom_range(0, 3) == 0) b[($urandom_range(0, 2))*LN +: LN] = '0;
      step("rand", e, b, {$urandom, $urandom, $urandom},
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
